// File: rtl/clock_hms.sv
// clock_hms: tick-prescaled 24-hour BCD time-of-day counter with run/stop, validated load and day carry
module clock_hms #(
  parameter logic [7:0] TICKS_PER_SEC = 8'd1,
  parameter logic [7:0] MAX_HOUR = 8'h23
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_tick,
  input  logic       I_run,
  input  logic       I_load,
  input  logic [7:0] I_hh,
  input  logic [7:0] I_mm,
  input  logic [7:0] I_ss,
  output logic [7:0] o_hh,
  output logic [7:0] o_mm,
  output logic [7:0] o_ss,
  output logic       o_day_cout,
  output logic       o_load_err,
  output logic       o_running
);
  typedef enum logic {STOP, RUN} state_t;
  state_t state, state_nxt;
  logic [7:0] pre_cnt;
  logic cnt, adv, ok, s_wrap, m_wrap, h_wrap;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  function automatic logic nib_ok(input logic [7:0] v);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9;
  endfunction
  always_comb begin
    state_nxt = I_run ? RUN : STOP;
    cnt = state == RUN && I_tick;
    adv = cnt && pre_cnt == TICKS_PER_SEC - 8'd1;
    ok = nib_ok(I_hh) && nib_ok(I_mm) && nib_ok(I_ss) && I_ss <= 8'h59 && I_mm <= 8'h59 && I_hh <= MAX_HOUR;
    s_wrap = o_ss == 8'h59;
    m_wrap = o_mm == 8'h59;
    h_wrap = o_hh == MAX_HOUR;
  end
  always_ff @(posedge I_clk)
    if (I_rst) state <= STOP;
    else state <= state_nxt;
  assign o_running = state == RUN;
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      pre_cnt <= 8'd0;
      o_hh <= 8'h00;
      o_mm <= 8'h00;
      o_ss <= 8'h00;
      o_day_cout <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      o_day_cout <= 1'b0;
      o_load_err <= I_load && !ok;
      if (I_load) begin
        if (ok) begin
          o_hh <= I_hh;
          o_mm <= I_mm;
          o_ss <= I_ss;
          pre_cnt <= 8'd0;
        end
      end else if (cnt) begin
        pre_cnt <= adv ? 8'd0 : pre_cnt + 8'd1;
        if (adv) begin
          o_ss <= s_wrap ? 8'h00 : bcd_inc(o_ss);
          if (s_wrap) o_mm <= m_wrap ? 8'h00 : bcd_inc(o_mm);
          if (s_wrap && m_wrap) o_hh <= h_wrap ? 8'h00 : bcd_inc(o_hh);
          o_day_cout <= s_wrap && m_wrap && h_wrap;
        end
      end
    end
  end
endmodule

// File: tb/tb_clock_hms.sv
// tb_clock_hms: scoreboard bench driving a 1-tick and a 27-tick clock_hms with directed vectors
module tb_clock_hms;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0, tick = 1'b0, load = 1'b0;
  logic [7:0] hh = 8'h00, mm = 8'h00, ss = 8'h00;
  logic [7:0] h1, m1, s1, h27, m27, s27;
  logic dc1, le1, r1, dc27, le27, r27;
  int cyc = 0, total = 0, bad = 0;
  typedef struct {
    int cyc;
    bit sel;
    logic [7:0] hh, mm, ss;
    logic day, err, run;
    logic [63:0] name;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [26:0] act, req;
  clock_hms #(.TICKS_PER_SEC(8'd1)) d1 (
    .I_clk(clk), .I_rst(rst), .I_tick(tick), .I_run(run), .I_load(load),
    .I_hh(hh), .I_mm(mm), .I_ss(ss), .o_hh(h1), .o_mm(m1), .o_ss(s1),
    .o_day_cout(dc1), .o_load_err(le1), .o_running(r1)
  );
  clock_hms #(.TICKS_PER_SEC(8'd27)) d27 (
    .I_clk(clk), .I_rst(rst), .I_tick(tick), .I_run(run), .I_load(load),
    .I_hh(hh), .I_mm(mm), .I_ss(ss), .o_hh(h27), .o_mm(m27), .o_ss(s27),
    .o_day_cout(dc27), .o_load_err(le27), .o_running(r27)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = e.sel ? {h27, m27, s27, dc27, le27, r27} : {h1, m1, s1, dc1, le1, r1};
      req = {e.hh, e.mm, e.ss, e.day, e.err, e.run};
      total = total + 1;
      if (act !== req) begin
        bad = bad + 1;
        $display("FAIL %0s dut%0d got hh:mm:ss=%h:%h:%h day=%b err=%b run=%b want %h:%h:%h day=%b err=%b run=%b",
                 e.name, e.sel ? 27 : 1, act[26:19], act[18:11], act[10:3], act[2], act[1], act[0],
                 e.hh, e.mm, e.ss, e.day, e.err, e.run);
      end
    end
  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + n % 10);
  endfunction
  task automatic step(input logic r, input logic rn, input logic t, input logic l,
                      input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    rst = r; run = rn; tick = t; load = l; hh = h; mm = m; ss = s;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_(input bit sel, input logic [63:0] name, input logic [7:0] h,
                         input logic [7:0] m, input logic [7:0] s, input logic day,
                         input logic err, input logic rn);
    q.push_back('{cyc, sel, h, m, s, day, err, rn, name});
  endtask
  task automatic ticks(input int n, input logic rn);
    for (int i = 0; i < n; i++) step(0, rn, 1, 0, 0, 0, 0);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    expect_(0, "reset", 8'h00, 8'h00, 8'h00, 0, 0, 0);
    expect_(1, "reset27", 8'h00, 8'h00, 8'h00, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    expect_(0, "run_on", 8'h00, 8'h00, 8'h00, 0, 0, 1);
    for (int i = 1; i <= 60; i++) begin
      step(0, 1, 1, 0, 0, 0, 0);
      expect_(0, "sec_cnt", 8'h00, i == 60 ? 8'h01 : 8'h00, to_bcd(i % 60), 0, 0, 1);
    end
    step(0, 1, 0, 1, 8'h23, 8'h59, 8'h58);
    expect_(0, "ld_2358", 8'h23, 8'h59, 8'h58, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    expect_(0, "t_2359", 8'h23, 8'h59, 8'h59, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    expect_(0, "day_wrap", 8'h00, 8'h00, 8'h00, 1, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    expect_(0, "day_off", 8'h00, 8'h00, 8'h00, 0, 0, 1);
    step(0, 1, 0, 1, 8'h24, 8'h00, 8'h00);
    expect_(0, "bad_hh", 8'h00, 8'h00, 8'h00, 0, 1, 1);
    step(0, 1, 0, 1, 8'h12, 8'h5A, 8'h00);
    expect_(0, "bad_nib", 8'h00, 8'h00, 8'h00, 0, 1, 1);
    step(0, 1, 0, 1, 8'h12, 8'h60, 8'h00);
    expect_(0, "bad_mm", 8'h00, 8'h00, 8'h00, 0, 1, 1);
    step(0, 1, 1, 1, 8'h24, 8'h00, 8'h00);
    expect_(0, "bad_tick", 8'h00, 8'h00, 8'h00, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    expect_(0, "err_off", 8'h00, 8'h00, 8'h00, 0, 0, 1);
    step(0, 1, 0, 1, 8'h23, 8'h59, 8'h59);
    expect_(0, "ld_max", 8'h23, 8'h59, 8'h59, 0, 0, 1);
    step(0, 1, 0, 1, 8'h00, 8'h00, 8'h00);
    expect_(1, "ld_zero", 8'h00, 8'h00, 8'h00, 0, 0, 1);
    ticks(26, 1);
    expect_(1, "pre_26", 8'h00, 8'h00, 8'h00, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    expect_(1, "run_off", 8'h00, 8'h00, 8'h00, 0, 0, 0);
    ticks(5, 0);
    expect_(1, "stop_tk", 8'h00, 8'h00, 8'h00, 0, 0, 0);
    expect_(0, "stop_tk1", 8'h00, 8'h00, 8'h26, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    expect_(1, "restart", 8'h00, 8'h00, 8'h00, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    expect_(1, "tick_27", 8'h00, 8'h00, 8'h01, 0, 0, 1);
    expect_(0, "tick_27b", 8'h00, 8'h00, 8'h27, 0, 0, 1);
    step(0, 1, 0, 1, 8'h00, 8'h00, 8'h59);
    ticks(26, 1);
    expect_(1, "pre_59", 8'h00, 8'h00, 8'h59, 0, 0, 1);
    step(0, 1, 1, 1, 8'h10, 8'h20, 8'h30);
    expect_(1, "ld_win", 8'h10, 8'h20, 8'h30, 0, 0, 1);
    expect_(0, "ld_win1", 8'h10, 8'h20, 8'h30, 0, 0, 1);
    ticks(26, 1);
    expect_(1, "pre_clr", 8'h10, 8'h20, 8'h30, 0, 0, 1);
    expect_(0, "ld_run1", 8'h10, 8'h20, 8'h56, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    expect_(1, "pre_27", 8'h10, 8'h20, 8'h31, 0, 0, 1);
    expect_(0, "ld_run1b", 8'h10, 8'h20, 8'h57, 0, 0, 1);
    step(0, 1, 0, 1, 8'h05, 8'h59, 8'h59);
    expect_(0, "ld_0559", 8'h05, 8'h59, 8'h59, 0, 0, 1);
    step(1, 1, 1, 1, 8'h23, 8'h59, 8'h59);
    expect_(0, "mid_rst", 8'h00, 8'h00, 8'h00, 0, 0, 0);
    expect_(1, "mid_rst27", 8'h00, 8'h00, 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    expect_(0, "post_rst", 8'h00, 8'h00, 8'h00, 0, 0, 0);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      bad = bad + 1;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clock_hms.md
Name: clock_hms

Overview:
- Downstream consumer of the tick counter's one-cycle carry pulse (o_cout), fed here as I_tick.
- Prescales ticks into seconds and maintains a 24-hour BCD time of day (hh:mm:ss).
- Supports run/stop control, validated parallel load and an end-of-day carry pulse for further cascading.

Parameters:
TICKS_PER_SEC, 8'd1, number of I_tick pulses per one-second advance; legal range 1..255.
MAX_HOUR, 8'h23, BCD value of the highest hour; hour wraps to 8'h00 after it.

Ports:
I_clk  input  1  rising-edge clock.
I_rst  input  1  synchronous, active-high reset.
I_tick  input  1  one-cycle tick pulse from the upstream counter carry.
I_run  input  1  level; 1 = count, 0 = hold.
I_load  input  1  one-cycle load strobe.
I_hh  input  8  BCD hour to load.
I_mm  input  8  BCD minute to load.
I_ss  input  8  BCD second to load.
o_hh  output  8  BCD hour.
o_mm  output  8  BCD minute.
o_ss  output  8  BCD second.
o_day_cout  output  1  one-cycle pulse on the hh wrap to 00.
o_load_err  output  1  one-cycle pulse when a load is rejected.
o_running  output  1  1 while FSM is in RUN.

Behaviour:
- Clocking and reset:
  - Single clock I_clk; reset I_rst is synchronous and active-high, sampled on the rising edge of I_clk.
  - On reset: o_hh, o_mm and o_ss = 8'h00; o_day_cout, o_load_err and o_running = 0; prescaler = 0; FSM = STOP.
  - Reset asserted mid-count discards all state at that edge; no carry is emitted.
- FSM:
  - STOP -> RUN when I_run = 1; RUN -> STOP when I_run = 0.
  - o_running is the registered state.
  - Ticks are counted only when the registered state is RUN. The tick sampled on the same edge that leaves STOP is ignored.
- Prescaler:
  - 8-bit register pre_cnt.
  - In RUN with I_tick = 1: if pre_cnt == TICKS_PER_SEC - 1, then pre_cnt <= 0 and the seconds advance; otherwise pre_cnt <= pre_cnt + 1.
  - pre_cnt holds its value in STOP.
- BCD advance, 1-cycle latency (new value visible after the edge that sampled the qualifying tick):
  - Seconds: low digit 9 -> 0 with high digit + 1; 8'h59 -> 8'h00 and a minute carry.
  - Minutes: same rule as seconds; 8'h59 -> 8'h00 and an hour carry.
  - Hours: increment in BCD; o_hh == MAX_HOUR -> 8'h00, with o_day_cout = 1 for exactly that cycle.
  - All three fields update on the same edge; there is no ripple delay.
- Load:
  - Acts on the edge where I_load = 1, in either FSM state.
  - Valid load requires every BCD nibble ≤ 9, I_ss ≤ 8'h59, I_mm ≤ 8'h59 and I_hh ≤ MAX_HOUR.
  - Valid load: o_hh, o_mm, o_ss <= inputs; pre_cnt <= 0; o_load_err = 0.
  - Invalid load: time and pre_cnt unchanged; o_load_err = 1 for one cycle.
  - Load coincident with a qualifying tick: load wins and the tick is dropped, for both valid and invalid loads.
  - Load of 8'h23:59:59 does not itself produce o_day_cout.
- Pulse outputs and counting rules:
  - o_day_cout and o_load_err are registered and deassert the next cycle unless retriggered.
  - I_tick held high for multiple cycles counts once per cycle.
  - I_run and I_load have no effect while I_rst = 1.

Test Plan:
1. Reset, then I_run = 1 with TICKS_PER_SEC = 1 and 60 ticks -> o_ss counts 00..59 then 00; o_mm = 8'h01; o_running = 1 from the cycle after I_run rises.
2. Load 23:59:58, run, 2 ticks -> 23:59:59, then 00:00:00 with o_day_cout = 1 for exactly one cycle.
3. Load 8'h24:00:00, then 8'h12:5A:00, then 8'h12:60:00 -> each gives o_load_err = 1 for one cycle and time is unchanged.
4. TICKS_PER_SEC = 27 (the upstream counter PERIOD value), 26 ticks, drop I_run, 5 idle ticks, raise I_run, 1 tick -> o_ss goes 00 -> 01 only on the 27th counted tick; ticks in STOP are ignored.
5. I_load of 10:20:30 coincident with a qualifying tick at 00:00:59 -> output is 10:20:30, with no minute advance and pre_cnt = 0.
6. Assert I_rst for one cycle mid-run at 05:59:59 with a coincident tick -> all outputs 0, FSM in STOP, no o_day_cout.
